ddr_rd_arbiter: RTL and testbench
=================================

DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 Parameter ADDR_W, 22, DDR word address width.
REQ-002 Parameter DATA_W, 256, DDR data width.
REQ-003 Parameter BURST_W, 5, burst count width.
REQ-004 Parameter TAG_DEPTH, 4, outstanding-burst tag FIFO depth (power of 2).
REQ-005 ddr_emif_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 ddr_emif_rst_n  in  1  asynchronous active-low reset.
REQ-007 rq0_read / rq1_read  in  1  requester read request, held until ack.
REQ-008 rq0_addr / rq1_addr  in  ADDR_W  requester start address, stable while read held.
REQ-009 rq0_burst / rq1_burst  in  BURST_W  requester burst length, stable while read held.
REQ-010 rq0_ack / rq1_ack  out  1  one-cycle pulse: command accepted by DDR.
REQ-011 rq0_rdata / rq1_rdata  out  DATA_W  routed read data.
REQ-012 rq0_rvalid / rq1_rvalid  out  1  routed read-data valid.
REQ-013 ddr_emif_ready  in  1  DDR waitrequest-inverse.
REQ-014 ddr_emif_read  out  1  DDR read command.
REQ-015 ddr_emif_addr  out  ADDR_W; ddr_emif_burst_count out BURST_W; ddr_emif_byte_enable out DATA_W/8.
REQ-016 ddr_emif_read_data  in  DATA_W; ddr_emif_rddata_valid  in  1.
REQ-017 ddr_emif_write  out  1, tied 0; ddr_emif_write_data  out  DATA_W, tied 0.
REQ-018 busy  out  1; err_unexp_rd  out  1 sticky error.

Function
REQ-019 FSM states IDLE, ISSUE; IDLE evaluates requests each cycle.
REQ-020 IDLE -> ISSUE when any rqN_read=1 and tag FIFO not full; winner's addr/burst/id registered on that edge.
REQ-021 In ISSUE ddr_emif_read=1 with registered addr/burst, byte_enable all ones; held while ddr_emif_ready=0.
REQ-022 ISSUE with ddr_emif_ready=1: command accepted, winner's rqN_ack=1 that cycle, {id,burst} pushed to tag FIFO, next state IDLE.
REQ-023 Command throughput: at most one accepted command per 2 cycles; first ddr_emif_read one cycle after request seen.
REQ-024 Burst value 0 is issued and tagged as 1.
REQ-025 Tag FIFO full: no arbitration; rqN_read ignored, no ack.
REQ-026 Return path: each ddr_emif_rddata_valid beat routed combinationally to head-tag requester (rqN_rdata=ddr_emif_read_data, rqN_rvalid=1); other requester rvalid=0.
REQ-027 Beat counter (BURST_W bits) increments per beat; at beat == tag burst-1 the tag pops and counter clears.
REQ-028 Push and pop in same cycle allowed; occupancy unchanged.
REQ-029 rddata_valid with FIFO empty: beat dropped, err_unexp_rd set until reset.
REQ-030 busy=1 when state=ISSUE or FIFO non-empty.
REQ-031 rqN_rdata driven with ddr_emif_read_data regardless of valid.

Reset
REQ-032 Reset: state IDLE, FIFO empty, beat counter 0, ddr_emif_read=0, addr/burst 0, all acks/rvalids 0, busy=0, err_unexp_rd=0, round-robin pointer favours rq0.
REQ-033 Reset mid-operation aborts issued command and discards outstanding tags; later returns flag err_unexp_rd.

Configuration
REQ-034 Macro DDR_RD_ARB_RR_EN defined: round-robin; requester last acked loses ties on next arbitration.
REQ-035 Macro DDR_RD_ARB_RR_EN undefined: fixed priority, rq0 always wins ties; pointer logic absent.

Verification
REQ-036 rq0_read, addr 0x10, burst 4, ready=1 -> ddr_emif_read one cycle, addr 0x10, count 4; rq0_ack pulse; 4 return beats -> rq0_rvalid x4, busy falls after last.
REQ-037 rq0 and rq1 held continuously, burst 1 -> RR_EN: acks alternate 0,1,0,1; without macro: rq0 acked every command, rq1 never.
REQ-038 ready=0 for 5 cycles during ISSUE -> read/addr stable 5 cycles, ack only on cycle ready=1.
REQ-039 Five rq1 commands, no returns -> 4 acks, fifth held unacked until first burst fully returned.
REQ-040 rddata_valid with nothing outstanding -> no rvalid, err_unexp_rd=1 and held; reset during ISSUE -> read=0 immediately, err cleared.
REQ-041 Burst 0 request -> burst_count 1 issued, single beat pops tag.

Source files
------------

// File: rtl/ddr_rd_arbiter.sv
// Two-requester DDR read arbiter; a tag FIFO routes returned beats back to the issuing requester.
// Define DDR_RD_ARB_RR_EN for round-robin arbitration, otherwise rq0 has fixed priority.
module ddr_rd_arbiter #(
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BURST_W   = 5,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                ddr_emif_clk,
  input  logic                ddr_emif_rst_n,
  input  logic                rq0_read,
  input  logic [ADDR_W-1:0]   rq0_addr,
  input  logic [BURST_W-1:0]  rq0_burst,
  output logic                rq0_ack,
  output logic [DATA_W-1:0]   rq0_rdata,
  output logic                rq0_rvalid,
  input  logic                rq1_read,
  input  logic [ADDR_W-1:0]   rq1_addr,
  input  logic [BURST_W-1:0]  rq1_burst,
  output logic                rq1_ack,
  output logic [DATA_W-1:0]   rq1_rdata,
  output logic                rq1_rvalid,
  input  logic                ddr_emif_ready,
  output logic                ddr_emif_read,
  output logic [ADDR_W-1:0]   ddr_emif_addr,
  output logic [BURST_W-1:0]  ddr_emif_burst_count,
  output logic [DATA_W/8-1:0] ddr_emif_byte_enable,
  input  logic [DATA_W-1:0]   ddr_emif_read_data,
  input  logic                ddr_emif_rddata_valid,
  output logic                ddr_emif_write,
  output logic [DATA_W-1:0]   ddr_emif_write_data,
  output logic                busy,
  output logic                err_unexp_rd
);

  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TAG_W = BURST_W + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [BURST_W-1:0]   burst_q;
  logic                 id_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BURST_W-1:0]   beat_q;
  logic                 err_q;
  logic [TAG_W-1:0]     tag_mem [TAG_DEPTH];

  logic                 any_req, fifo_full, fifo_empty;
  logic                 launch, accept, beat, pop;
  logic                 win_id;
  logic [ADDR_W-1:0]    win_addr;
  logic [BURST_W-1:0]   win_burst, win_burst_raw;
  logic [TAG_W-1:0]     head_tag;
  logic                 head_id;
  logic [BURST_W-1:0]   head_burst;

  assign any_req    = rq0_read | rq1_read;
  assign fifo_full  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (cnt_q == '0);

`ifdef DDR_RD_ARB_RR_EN
  logic rr_q;  // requester favoured on a tie; the one last acked loses

  always_comb begin
    win_id = ~rq0_read;
    if (rq0_read && rq1_read) win_id = rr_q;
  end

  always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
    if (!ddr_emif_rst_n)  rr_q <= 1'b0;
    else if (accept)      rr_q <= ~id_q;
  end
`else
  assign win_id = ~rq0_read;
`endif

  assign win_addr      = win_id ? rq1_addr  : rq0_addr;
  assign win_burst_raw = win_id ? rq1_burst : rq0_burst;
  // A zero burst length is treated as a single-beat burst end to end
  assign win_burst     = (win_burst_raw == '0) ? BURST_W'(1) : win_burst_raw;

  // FSM state register
  always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
    if (!ddr_emif_rst_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req && !fifo_full) state_d = ISSUE;
      ISSUE:   if (ddr_emif_ready)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ddr_emif_read = 1'b0;
    rq0_ack       = 1'b0;
    rq1_ack       = 1'b0;
    launch        = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE:  launch = any_req && !fifo_full;
      ISSUE: begin
        ddr_emif_read = 1'b1;
        accept        = ddr_emif_ready;
        rq0_ack       = ddr_emif_ready && !id_q;
        rq1_ack       = ddr_emif_ready &&  id_q;
      end
      default: ;
    endcase
  end

  // Winning command captured when leaving IDLE
  always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
    if (!ddr_emif_rst_n) begin
      addr_q  <= '0;
      burst_q <= '0;
      id_q    <= 1'b0;
    end else if (launch) begin
      addr_q  <= win_addr;
      burst_q <= win_burst;
      id_q    <= win_id;
    end
  end

  assign head_tag   = tag_mem[rd_ptr_q];
  assign head_id    = head_tag[BURST_W];
  assign head_burst = head_tag[BURST_W-1:0];
  assign beat       = ddr_emif_rddata_valid && !fifo_empty;
  assign pop        = beat && (beat_q == (head_burst - BURST_W'(1)));
  assign cnt_d      = cnt_q + CNT_W'(accept) - CNT_W'(pop);

  always_ff @(posedge ddr_emif_clk) begin
    if (accept) tag_mem[wr_ptr_q] <= {id_q, burst_q};
  end

  // Tag FIFO pointers, beat counter and sticky error
  always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
    if (!ddr_emif_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
      if (pop)       beat_q <= '0;
      else if (beat) beat_q <= beat_q + BURST_W'(1);
      if (ddr_emif_rddata_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign rq0_rdata            = ddr_emif_read_data;
  assign rq1_rdata            = ddr_emif_read_data;
  assign rq0_rvalid           = beat && !head_id;
  assign rq1_rvalid           = beat &&  head_id;
  assign ddr_emif_addr        = addr_q;
  assign ddr_emif_burst_count = burst_q;
  assign ddr_emif_byte_enable = '1;
  assign ddr_emif_write       = 1'b0;
  assign ddr_emif_write_data  = '0;
  assign busy                 = (state_q == ISSUE) || !fifo_empty;
  assign err_unexp_rd         = err_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Self-checking bench for ddr_rd_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-based transaction model.
module tb_ddr_rd_arbiter;
  localparam int unsigned ADDR_W    = 22;
  localparam int unsigned DATA_W    = 256;
  localparam int unsigned BURST_W   = 5;
  localparam int unsigned TAG_DEPTH = 4;

  logic                clk, rst_n;
  logic                rq0_read, rq1_read;
  logic [ADDR_W-1:0]   rq0_addr, rq1_addr;
  logic [BURST_W-1:0]  rq0_burst, rq1_burst;
  logic                rq0_ack, rq1_ack, rq0_rvalid, rq1_rvalid;
  logic [DATA_W-1:0]   rq0_rdata, rq1_rdata;
  logic                ready, ddr_read, rdv, ddr_write, busy, err;
  logic [ADDR_W-1:0]   ddr_addr;
  logic [BURST_W-1:0]  ddr_burst;
  logic [DATA_W/8-1:0] ddr_be;
  logic [DATA_W-1:0]   rd_data, wr_data;

  ddr_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .ddr_emif_clk(clk), .ddr_emif_rst_n(rst_n),
    .rq0_read(rq0_read), .rq0_addr(rq0_addr), .rq0_burst(rq0_burst),
    .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata), .rq0_rvalid(rq0_rvalid),
    .rq1_read(rq1_read), .rq1_addr(rq1_addr), .rq1_burst(rq1_burst),
    .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata), .rq1_rvalid(rq1_rvalid),
    .ddr_emif_ready(ready), .ddr_emif_read(ddr_read), .ddr_emif_addr(ddr_addr),
    .ddr_emif_burst_count(ddr_burst), .ddr_emif_byte_enable(ddr_be),
    .ddr_emif_read_data(rd_data), .ddr_emif_rddata_valid(rdv),
    .ddr_emif_write(ddr_write), .ddr_emif_write_data(wr_data),
    .busy(busy), .err_unexp_rd(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one pending command plus a queue of outstanding bursts
  bit m_cmd, m_id, m_rr, m_err;
  int m_addr, m_burst, m_beats;
  int q_id[$];
  int q_burst[$];
  bit e_ack0, e_ack1, e_rv0, e_rv1, m_full, m_win;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cmd = 0; m_id = 0; m_rr = 0; m_err = 0; m_beats = 0;
      q_id.delete(); q_burst.delete();
    end
    e_ack0 = m_cmd && ready && (m_id == 0);
    e_ack1 = m_cmd && ready && (m_id == 1);
    e_rv0  = rdv && (q_id.size() > 0) && (q_id[0] == 0);
    e_rv1  = rdv && (q_id.size() > 0) && (q_id[0] == 1);
    chk("read", ddr_read, m_cmd);
    if (m_cmd) begin
      chk("addr", ddr_addr, m_addr);
      chk("burst_count", ddr_burst, m_burst);
    end
    chk("ack0", rq0_ack, e_ack0);
    chk("ack1", rq1_ack, e_ack1);
    chk("rvalid0", rq0_rvalid, e_rv0);
    chk("rvalid1", rq1_rvalid, e_rv1);
    chk("rdata0", rq0_rdata, rd_data);
    chk("rdata1", rq1_rdata, rd_data);
    chk("busy", busy, m_cmd || (q_id.size() > 0));
    chk("err", err, m_err);
    if (rst_n) begin
      m_full = (q_id.size() >= TAG_DEPTH);
      if (rdv) begin
        if (q_id.size() == 0) m_err = 1;
        else begin
          m_beats++;
          if (m_beats == q_burst[0]) begin
            void'(q_id.pop_front());
            void'(q_burst.pop_front());
            m_beats = 0;
          end
        end
      end
      if (m_cmd) begin
        if (ready) begin
          q_id.push_back(int'(m_id));
          q_burst.push_back(m_burst);
          m_rr  = !m_id;
          m_cmd = 0;
        end
      end else if ((rq0_read || rq1_read) && !m_full) begin
`ifdef DDR_RD_ARB_RR_EN
        m_win = (rq0_read && rq1_read) ? m_rr : !rq0_read;
`else
        m_win = !rq0_read;
`endif
        m_cmd   = 1;
        m_id    = m_win;
        m_addr  = m_win ? int'(rq1_addr) : int'(rq0_addr);
        m_burst = m_win ? int'(rq1_burst) : int'(rq0_burst);
        if (m_burst == 0) m_burst = 1;
      end
    end
  end

  bit seen0, seen1;
  always @(negedge clk) begin
    seen0 = rq0_ack;
    seen1 = rq1_ack;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_until_ack(input bit id, input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] b,
                               input int maxc, output bit got);
    got = 0;
    if (id == 0) begin rq0_read = 1; rq0_addr = a; rq0_burst = b; end
    else         begin rq1_read = 1; rq1_addr = a; rq1_burst = b; end
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if ((id == 0) ? seen0 : seen1) got = 1;
    end
    if (got) begin
      if (id == 0) rq0_read = 0; else rq1_read = 0;
    end
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      rdv = (q_id.size() > 0);
      rd_data = {8{$urandom}};
      if (!rdv) break;
      step();
    end
    rdv = 0;
    #1 chk("drained_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  bit got;
  int acks, late;
  int order[$];
  int exp_order[4];

  initial begin
    rst_n = 0; rq0_read = 0; rq1_read = 0; rq0_addr = '0; rq1_addr = '0;
    rq0_burst = '0; rq1_burst = '0; ready = 0; rdv = 0; rd_data = '0;
    step();
    step();
    // Reset state
    chk("rst_read", ddr_read, 1'b0);
    chk("rst_addr", ddr_addr, 0);
    chk("rst_burst", ddr_burst, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_write", ddr_write, 1'b0);
    chk("rst_wdata", wr_data, 0);
    rst_n = 1;
    step();

    // Single rq0 burst of 4 at 0x10
    rq0_addr = 22'h10; rq0_burst = 5'd4; ready = 1; rq0_read = 1;
    step();
    #1;
    chk("s_read", ddr_read, 1'b1);
    chk("s_addr", ddr_addr, 22'h10);
    chk("s_count", ddr_burst, 5'd4);
    chk("s_be", ddr_be, 32'hFFFF_FFFF);
    chk("s_ack0", rq0_ack, 1'b1);
    rq0_read = 0;
    step();
    #1 chk("s_read_off", ddr_read, 1'b0);
    chk("s_busy_out", busy, 1'b1);
    for (int b = 0; b < 4; b++) begin
      rdv = 1; rd_data = {8{$urandom}};
      #1 chk("s_rvalid0", rq0_rvalid, 1'b1);
      chk("s_rvalid1", rq1_rvalid, 1'b0);
      step();
    end
    rdv = 0;
    #1 chk("s_busy_end", busy, 1'b0);

    // Burst 0 from rq1 issues as 1 and a single beat retires it
    rq1_addr = 22'h3ff; rq1_burst = 5'd0; rq1_read = 1;
    step();
    #1 chk("z_count", ddr_burst, 5'd1);
    chk("z_ack1", rq1_ack, 1'b1);
    rq1_read = 0;
    step();
    rdv = 1;
    #1 chk("z_rvalid1", rq1_rvalid, 1'b1);
    step();
    rdv = 0;
    #1 chk("z_busy", busy, 1'b0);

    // Command stalled by ready=0 for 5 cycles
    ready = 0; rq0_addr = 22'h55; rq0_burst = 5'd2; rq0_read = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      #1 chk("w_read", ddr_read, 1'b1);
      chk("w_addr", ddr_addr, 22'h55);
      chk("w_noack", rq0_ack, 1'b0);
      step();
    end
    ready = 1;
    #1 chk("w_ack", rq0_ack, 1'b1);
    rq0_read = 0;
    step();
    drain(20);

    // Five rq1 commands with no returns: the fifth waits for the first burst
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      req_until_ack(1, ADDR_W'(32'h100 + k), 5'd2, 12, got);
      if (got) acks++;
    end
    chk("f_acks", acks, 4);
    rq1_read = 1; rq1_addr = 22'h200; rq1_burst = 5'd2;
    late = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (seen1) late++;
    end
    chk("f_fifth_held", late, 0);
    rdv = 1;
    step();
    step();
    rdv = 0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (seen1) got = 1;
    end
    chk("f_fifth_acked", got, 1'b1);
    rq1_read = 0;
    drain(40);

    // Both requesters held, burst 1
    do_reset();
    rq0_addr = 22'h1; rq1_addr = 22'h2; rq0_burst = 5'd1; rq1_burst = 5'd1;
    rq0_read = 1; rq1_read = 1; ready = 1;
    order.delete();
    for (int i = 0; i < 30 && order.size() < 4; i++) begin
      rdv = (q_id.size() > 0);
      step();
      if (seen0) order.push_back(0);
      if (seen1) order.push_back(1);
    end
`ifdef DDR_RD_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    chk("t_count", order.size(), 4);
    for (int i = 0; i < 4; i++) chk("t_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    rq0_read = 0; rq1_read = 0;
    step();
    step();
    drain(20);

    // Unexpected return sets sticky error; reset mid-issue clears everything
    rdv = 1;
    #1 chk("u_rv0", rq0_rvalid, 1'b0);
    chk("u_rv1", rq1_rvalid, 1'b0);
    step();
    rdv = 0;
    #1 chk("u_err", err, 1'b1);
    step();
    #1 chk("u_err_held", err, 1'b1);
    ready = 0; rq0_read = 1; rq0_addr = 22'h77; rq0_burst = 5'd3;
    step();
    #1 chk("r_issue", ddr_read, 1'b1);
    rst_n = 0;
    #1 chk("r_read_off", ddr_read, 1'b0);
    chk("r_err_clr", err, 1'b0);
    chk("r_busy", busy, 1'b0);
    rq0_read = 0;
    step();
    rst_n = 1;
    step();

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      step();
      if (rq0_read && seen0) begin
        if ($urandom_range(1) == 1) begin rq0_addr = ADDR_W'($urandom); rq0_burst = BURST_W'($urandom_range(0, 6)); end
        else rq0_read = 0;
      end else if (!rq0_read && $urandom_range(9) < 4) begin
        rq0_read = 1; rq0_addr = ADDR_W'($urandom); rq0_burst = BURST_W'($urandom_range(0, 6));
      end
      if (rq1_read && seen1) begin
        if ($urandom_range(1) == 1) begin rq1_addr = ADDR_W'($urandom); rq1_burst = BURST_W'($urandom_range(0, 6)); end
        else rq1_read = 0;
      end else if (!rq1_read && $urandom_range(9) < 4) begin
        rq1_read = 1; rq1_addr = ADDR_W'($urandom); rq1_burst = BURST_W'($urandom_range(0, 6));
      end
      ready = ($urandom_range(3) != 0);
      rdv = (q_id.size() > 0) && ($urandom_range(1) == 1);
      rd_data = {8{$urandom}};
    end
    rq0_read = 0; rq1_read = 0; rdv = 0; ready = 1;
    step();
    step();
    drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
